// File: rtl/if_stage_pipe.sv
// Instruction-fetch PC register and IF/ID pipeline register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stallPC,
  input  logic        IFID_stall,
  input  logic        IFID_flush,
  input  logic        EX_PCSrc,
  input  logic [31:0] EX_branchTarget,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] IFID_pc_o,
  output logic [31:0] IFID_pcPlus4_o,
  output logic [31:0] IFID_instr_o,
  output logic        IFID_valid_o,
  output logic [31:0] stallCount_o,
  output logic [31:0] flushCount_o
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;

  assign pc_plus4 = pc_q + XLEN'(4);

  // Redirect beats stall; targets are forced word aligned.
  always_comb begin
    pc_d = pc_plus4;
    if (EX_PCSrc) begin
      pc_d = {EX_branchTarget[XLEN-1:2], 2'b00};
    end else if (stallPC) begin
      pc_d = pc_q;
    end
  end

  // Flush beats stall in the IF/ID register.
  always_comb begin
    ifid_pc_d    = pc_q;
    ifid_pc4_d   = pc_plus4;
    ifid_instr_d = imem_instr_i;
    ifid_valid_d = 1'b1;
    if (IFID_flush) begin
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else if (IFID_stall) begin
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr_o    = pc_q;
  assign IFID_pc_o      = ifid_pc_q;
  assign IFID_pcPlus4_o = ifid_pc4_q;
  assign IFID_instr_o   = ifid_instr_q;
  assign IFID_valid_o   = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; a flush cycle is not counted as a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (IFID_flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + XLEN'(1);
    end else if (IFID_stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount_o = stall_cnt_q;
  assign flushCount_o = flush_cnt_q;
`else
  assign stallCount_o = '0;
  assign flushCount_o = '0;
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Self-checking bench for if_stage_pipe: directed scenarios plus random stimulus
// against a cycle-level reference model of the fetch/IF-ID rules.
module tb_if_stage_pipe;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall_pc, ifid_stall, ifid_flush, pcsrc;
  logic [31:0] target;
  logic [31:0] imem_addr, imem_instr;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr, stall_cnt, flush_cnt;
  logic        ifid_valid;

  int tests = 0;
  int errs  = 0;

  // Model state
  logic [31:0] m_pc, m_ipc, m_ip4, m_ins, m_sc, m_fc;
  logic        m_val;

  always #5 clk = ~clk;

  if_stage_pipe #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst), .stallPC(stall_pc), .IFID_stall(ifid_stall),
    .IFID_flush(ifid_flush), .EX_PCSrc(pcsrc), .EX_branchTarget(target),
    .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .IFID_pc_o(ifid_pc), .IFID_pcPlus4_o(ifid_pc4), .IFID_instr_o(ifid_instr),
    .IFID_valid_o(ifid_valid), .stallCount_o(stall_cnt), .flushCount_o(flush_cnt)
  );

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_instr = imem_fn(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently applied inputs.
  task automatic model_edge();
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (rst) begin
      m_pc = RST_PC; m_ipc = 0; m_ip4 = 0; m_ins = 0; m_val = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (pcsrc) m_pc = target & ~32'd3;
      else if (!stall_pc) m_pc = old_pc + 32'd4;
      if (ifid_flush) begin
        m_ipc = 0; m_ip4 = 0; m_ins = 0; m_val = 0;
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end else if (ifid_stall) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else begin
        m_ipc = old_pc; m_ip4 = old_pc + 32'd4; m_ins = imem_fn(old_pc); m_val = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    imem_addr,  m_pc);
    chk({tag, ".ipc"},   ifid_pc,    m_ipc);
    chk({tag, ".ip4"},   ifid_pc4,   m_ip4);
    chk({tag, ".ins"},   ifid_instr, m_ins);
    chk({tag, ".val"},   32'(ifid_valid), 32'(m_val));
`ifdef IF_PERF_CNT_EN
    chk({tag, ".scnt"},  stall_cnt,  m_sc);
    chk({tag, ".fcnt"},  flush_cnt,  m_fc);
`else
    chk({tag, ".scnt"},  stall_cnt,  32'h0);
    chk({tag, ".fcnt"},  flush_cnt,  32'h0);
`endif
  endtask

  task automatic drive(input logic r, input logic sp, input logic is, input logic fl,
                       input logic br, input logic [31:0] t);
    rst = r; stall_pc = sp; ifid_stall = is; ifid_flush = fl; pcsrc = br; target = t;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    m_pc = 0; m_ipc = 0; m_ip4 = 0; m_ins = 0; m_val = 0; m_sc = 0; m_fc = 0;
    drive(1, 0, 0, 0, 0, 0);
    #1;
    step("rst0");
    step("rst1");
    chk("rst.addr", imem_addr, 32'h100);
    chk("rst.valid", 32'(ifid_valid), 32'h0);

    drive(0, 0, 0, 0, 0, 0);
    step("run0");
    chk("run0.addr", imem_addr, 32'h104);
    chk("run0.ipc", ifid_pc, 32'h100);
    chk("run0.valid", 32'(ifid_valid), 32'h1);
    step("run1");
    chk("run1.addr", imem_addr, 32'h108);

    // Load-use stall at PC 0x10
    drive(0, 0, 0, 1, 1, 32'h10);
    step("to10");
    drive(0, 0, 0, 0, 0, 0);
    step("f10");
    drive(0, 1, 1, 0, 0, 0);
    step("stall");
    chk("stall.addr", imem_addr, 32'h14);
    chk("stall.ipc", ifid_pc, 32'h10);
    drive(0, 0, 0, 0, 0, 0);
    step("unstall");
    chk("unstall.ipc", ifid_pc, 32'h14);
    step("unstall2");

    // Branch redirect at PC 0x20 to 0x43
    drive(0, 0, 0, 1, 1, 32'h20);
    step("to20");
    drive(0, 0, 0, 1, 1, 32'h43);
    step("br");
    chk("br.addr", imem_addr, 32'h40);
    chk("br.valid", 32'(ifid_valid), 32'h0);
    chk("br.ins", ifid_instr, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    step("br1");
    chk("br1.ipc", ifid_pc, 32'h40);
    chk("br1.valid", 32'(ifid_valid), 32'h1);

    // Everything at once: redirect and flush win
    drive(0, 1, 1, 1, 1, 32'h80);
    step("all");
    chk("all.addr", imem_addr, 32'h80);
    chk("all.valid", 32'(ifid_valid), 32'h0);

    // Wrap at top of address space
    drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    step("topbr");
    drive(0, 0, 0, 0, 0, 0);
    step("wrap");
    chk("wrap.addr", imem_addr, 32'h0);
    chk("wrap.ip4", ifid_pc4, 32'h0);
    chk("wrap.ipc", ifid_pc, 32'hFFFF_FFFC);

    // Reset during an active stall
    drive(0, 1, 1, 0, 0, 0);
    step("prestall");
    drive(1, 1, 1, 0, 0, 0);
    step("rststall");
    chk("rststall.addr", imem_addr, RST_PC);
    chk("rststall.ipc", ifid_pc, 32'h0);
    chk("rststall.ins", ifid_instr, 32'h0);

    // Counter scenario: 3 stalls, 2 flushes, 1 stall+flush
    for (int i = 0; i < 3; i++) begin drive(0, 1, 1, 0, 0, 0); step("cs"); end
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 0, 0); step("cf"); end
    drive(0, 1, 1, 1, 0, 0);
    step("csf");
`ifdef IF_PERF_CNT_EN
    chk("cnt.stall", stall_cnt, 32'd3);
    chk("cnt.flush", flush_cnt, 32'd3);
`else
    chk("cnt.stall", stall_cnt, 32'd0);
    chk("cnt.flush", flush_cnt, 32'd0);
`endif

    // Random stimulus
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), $urandom);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
